// File: rtl/multiword_add_sequencer.sv
// Multi-word adder/subtractor that reuses one ADDER_WIDTH-bit lookahead adder,
// processing one word per cycle from LSW to MSW under a valid/ready handshake.

module lookahead_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH:0]   carries;

    // Every carry is a flat sum-of-products of generate/propagate terms, so no
    // carry depends on a neighbouring carry signal.
    function automatic logic [WIDTH:0] lookahead(input logic [WIDTH-1:0] g,
                                                 input logic [WIDTH-1:0] p,
                                                 input logic             c0);
        logic [WIDTH:0] c;
        logic           acc;
        logic           prod;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < WIDTH; i++) begin
            acc  = g[i];
            prod = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc  = acc | (prod & g[j]);
                prod = prod & p[j];
            end
            c[i+1] = acc | (prod & c0);
        end
        return c;
    endfunction

    assign gen     = a & b;
    assign prop    = a ^ b;
    assign carries = lookahead(gen, prop, cin);
    assign sum     = prop ^ carries[WIDTH-1:0];
    assign cout    = carries[WIDTH];

endmodule

module multiword_add_sequencer #(
    parameter int ADDER_WIDTH = 8,
    parameter int NUM_WORDS   = 4,
    localparam int W          = ADDER_WIDTH * NUM_WORDS
) (
    input  logic         iClk,
    input  logic         iRst,
    input  logic         iValid,
    output logic         oReady,
    input  logic [W-1:0] iA,
    input  logic [W-1:0] iB,
    input  logic         iCarry,
    input  logic         iSub,
    output logic         oValid,
    input  logic         iReady,
    output logic [W-1:0] oSum,
    output logic         oCarry,
    output logic         oOverflow,
    output logic         oBusy
);

    localparam int IDX_W = ($clog2(NUM_WORDS) > 0) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [NUM_WORDS-1:0][ADDER_WIDTH-1:0] a_words;
    logic [NUM_WORDS-1:0][ADDER_WIDTH-1:0] b_words;
    logic [NUM_WORDS-1:0][ADDER_WIDTH-1:0] sum_words;

    logic [IDX_W-1:0]       idx;
    logic                   carry;
    logic                   carry_out;
    logic                   overflow;
    logic [ADDER_WIDTH-1:0] word_sum;
    logic                   word_cout;
    logic                   accept;
    logic                   last_word;
    logic                   top_ovf;

    assign accept    = (state == IDLE) && iValid;
    assign last_word = (idx == LAST_IDX);

    lookahead_adder #(
        .WIDTH(ADDER_WIDTH)
    ) u_adder (
        .a   (a_words[idx]),
        .b   (b_words[idx]),
        .cin (carry),
        .sum (word_sum),
        .cout(word_cout)
    );

    // b_words already holds the inverted B for subtraction, so one rule covers both.
    assign top_ovf = (a_words[NUM_WORDS-1][ADDER_WIDTH-1] == b_words[NUM_WORDS-1][ADDER_WIDTH-1])
                     && (word_sum[ADDER_WIDTH-1] != a_words[NUM_WORDS-1][ADDER_WIDTH-1]);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (iValid)    state_next = RUN;
            RUN:  if (last_word) state_next = DONE;
            DONE: if (iReady)    state_next = IDLE;
            default:             state_next = IDLE;
        endcase
    end

    // Operand capture has no reset: operands are only consumed after an accept.
    always_ff @(posedge iClk) begin
        if (!iRst && accept) begin
            a_words <= iA;
            b_words <= iSub ? ~iB : iB;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            idx       <= '0;
            carry     <= 1'b0;
            sum_words <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (iValid) begin
                        carry <= iCarry | iSub;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    sum_words[idx] <= word_sum;
                    carry          <= word_cout;
                    if (last_word) begin
                        idx       <= '0;
                        carry_out <= word_cout;
                        overflow  <= top_ovf;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign oReady    = (state == IDLE);
    assign oBusy     = (state == RUN);
    assign oValid    = (state == DONE);
    assign oSum      = sum_words;
    assign oCarry    = carry_out;
    assign oOverflow = overflow;

endmodule
